// File: rtl/fp_mini_pkg.sv
// Shared types and constants for the minifloat datapath.
// Rounding mode is selected by the FP_NORM_ROUND_EN macro.
package fp_mini_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int RAW_W = MAN_W + 3;

  localparam logic [EXP_W-1:0] EXP_INF  = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // full-adder cell: returns {carry, sum}
  function automatic logic [1:0] fa(
    input logic a,
    input logic b,
    input logic ci
  );
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/fp_exp_step.sv
// Ripple exponent incrementer/decrementer built from fa cells.
// lim: up -> result saturates at all-ones; down -> input is one.
module fp_exp_step
  import fp_mini_pkg::*;
(
  input  logic [EXP_W-1:0] a,
  input  logic             up,
  output logic [EXP_W-1:0] y,
  output logic             lim
);

  logic [EXP_W:0]   c;
  logic [EXP_W-1:0] b;

  // decrement adds all-ones (two's complement of one)
  assign b    = up ? EXP_W'(1) : '1;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < EXP_W; i++) begin : g_rip
    assign {c[i+1], y[i]} = fa(a[i], b[i], c[i]);
  end

  assign lim = up ? (c[EXP_W] | (y == EXP_INF))
                  : (a == EXP_W'(1));

endmodule

// File: rtl/fp_normalize.sv
// Multi-cycle post-add normalizer/packer for the minifloat path.
// FP_NORM_ROUND_EN selects half-up rounding, else truncation.
module fp_normalize
  import fp_mini_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [RAW_W-1:0] in_raw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_ovf,
  output logic             out_unf
);

  state_t           state, state_n;
  logic             sgn, sgn_n;
  logic [EXP_W-1:0] exp_q, exp_n;
  logic [RAW_W-1:0] raw_q, raw_n;
  fp_t              res_q, res_n;
  logic             ovf_q, ovf_n;
  logic             unf_q, unf_n;
  logic             vld_q, vld_n;

  logic             step_up;
  logic [EXP_W-1:0] step_y;
  logic             step_lim;
  logic             carry, hidden;
  logic [MAN_W-1:0] frac, rman;
  logic             rc;

  assign carry  = raw_q[RAW_W-1];
  assign hidden = raw_q[RAW_W-2];
  assign frac   = raw_q[MAN_W:1];

  // hidden is 1 in ROUND, so a fraction carry-out is the mantissa carry
`ifdef FP_NORM_ROUND_EN
  assign {rc, rman} = {1'b0, frac} + {{MAN_W{1'b0}}, raw_q[0]};
`else
  assign {rc, rman} = {1'b0, frac};
`endif

  assign step_up = (state == ROUND) | carry;

  fp_exp_step u_step (
    .a   (exp_q),
    .up  (step_up),
    .y   (step_y),
    .lim (step_lim)
  );

  always_comb begin
    state_n = state;
    sgn_n   = sgn;
    exp_n   = exp_q;
    raw_n   = raw_q;
    res_n   = res_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    vld_n   = vld_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sgn_n   = in_sign;
          exp_n   = in_exp;
          raw_n   = in_raw;
          state_n = NORM;
        end
      end
      NORM: begin
        state_n = DONE;
        res_n   = '{sign: sgn, exp: EXP_ZERO, man: '0};
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        if (raw_q != '0) begin
          if (exp_q == EXP_ZERO) begin
            unf_n = 1'b1;
          end else if (carry) begin
            raw_n = raw_q >> 1;
            exp_n = step_y;
            if (step_lim) begin
              res_n.exp = EXP_INF;
              ovf_n     = 1'b1;
            end else begin
              state_n = ROUND;
            end
          end else if (!hidden && exp_q == EXP_W'(1)) begin
            unf_n = 1'b1;
          end else if (!hidden) begin
            raw_n   = raw_q << 1;
            exp_n   = step_y;
            state_n = NORM;
          end else begin
            state_n = ROUND;
          end
        end
      end
      ROUND: begin
        state_n = DONE;
        res_n   = '{sign: sgn, exp: exp_q, man: rman};
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        if (rc) begin
          res_n.exp = step_y;
          res_n.man = '0;
          ovf_n     = step_lim;
        end
      end
      DONE: begin
        vld_n = 1'b1;
        if (vld_q && out_ready) begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sgn   <= 1'b0;
      exp_q <= '0;
      raw_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      sgn   <= sgn_n;
      exp_q <= exp_n;
      raw_q <= raw_n;
      res_q <= res_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
      vld_q <= vld_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = vld_q;
  assign out_sign  = res_q.sign;
  assign out_exp   = res_q.exp;
  assign out_man   = res_q.man;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: vector table, corner
// sequences and random operands against an arithmetic model.
module tb_fp_normalize;

`ifdef FP_NORM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic [2:0] in_exp = '0;
  logic [6:0] in_raw = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sign;
  logic [2:0] out_exp;
  logic [3:0] out_man;
  logic       out_ovf;
  logic       out_unf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_raw    (in_raw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  typedef struct {
    string nm;
    bit    s;
    int    e;
    int    r;
    int    xe;
    int    xm;
    int    xo;
    int    xu;
    int    xl;
  } vec_t;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endtask

  // value-level model: returns packed exp/man, flags, latency
  function automatic void model(
    input int e0, input int r0,
    output int xe, output int xm, output int xo,
    output int xu, output int xl
  );
    int e, r, l, m;
    e = e0; r = r0; l = 0;
    xe = 0; xm = 0; xo = 0; xu = 0; xl = 2;
    if (r == 0) return;
    if (e == 0) begin xu = 1; return; end
    if (r >= 64) begin
      r = r / 2;
      e = e + 1;
      if (e >= 7) begin xe = 7; xo = 1; return; end
    end else begin
      while (r < 32) begin
        if (e == 1) begin xu = 1; xl = 2 + l; return; end
        r = r * 2;
        e = e - 1;
        l = l + 1;
      end
    end
    xl = 3 + l;
    m = r / 2;
    if (RND) m = m + (r % 2);
    if (m >= 32) begin m = 16; e = e + 1; end
    if (e >= 7) begin xe = 7; xo = 1; xm = 0; end
    else begin xe = e; xm = m - 16; end
  endfunction

  task automatic apply(input vec_t v, input int hold);
    int cyc;
    check({v.nm, ".in_ready"}, int'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_sign   = v.s;
    in_exp    = 3'(v.e);
    in_raw    = 7'(v.r);
    @(posedge clk); #1;
    // keep garbage offered while busy; it must be ignored
    in_sign = ~v.s;
    in_exp  = 3'($urandom);
    in_raw  = 7'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({v.nm, ".lat"}, cyc, v.xl);
    check({v.nm, ".sign"}, int'(out_sign), int'(v.s));
    check({v.nm, ".exp"}, int'(out_exp), v.xe);
    check({v.nm, ".man"}, int'(out_man), v.xm);
    check({v.nm, ".ovf"}, int'(out_ovf), v.xo);
    check({v.nm, ".unf"}, int'(out_unf), v.xu);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({v.nm, ".hold_vld"}, int'(out_valid), 1);
      check({v.nm, ".hold_rdy"}, int'(in_ready), 0);
      check({v.nm, ".hold_exp"}, int'(out_exp), v.xe);
      check({v.nm, ".hold_man"}, int'(out_man), v.xm);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({v.nm, ".post_vld"}, int'(out_valid), 0);
    check({v.nm, ".post_rdy"}, int'(in_ready), 1);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    tbl.push_back('{"norm",    1'b0, 3, 7'b0100000, 3, 0, 0, 0, 3});
    tbl.push_back('{"cancel",  1'b0, 5, 7'b0000110, 2, 8, 0, 0, 6});
    tbl.push_back('{"carry_g", 1'b1, 2, 7'b1000011, 3,
                    RND ? 1 : 0, 0, 0, 3});
    tbl.push_back('{"ovf_n",   1'b0, 6, 7'b1000000, 7, 0, 1, 0, 2});
    tbl.push_back('{"ovf_r",   1'b0, 6, 7'b0111111,
                    RND ? 7 : 6, RND ? 0 : 15, RND ? 1 : 0, 0, 3});
    tbl.push_back('{"unf_sh",  1'b0, 2, 7'b0000001, 0, 0, 0, 1, 3});
    tbl.push_back('{"zero",    1'b1, 4, 7'b0000000, 0, 0, 0, 0, 2});
    tbl.push_back('{"exp0",    1'b0, 0, 7'b0100000, 0, 0, 0, 1, 2});
    tbl.push_back('{"unf_e1",  1'b1, 1, 7'b0010000, 0, 0, 0, 1, 2});
    tbl.push_back('{"guard",   1'b1, 3, 7'b0100001, 3,
                    RND ? 1 : 0, 0, 0, 3});

    #12;
    check("rst.vld", int'(out_valid), 0);
    check("rst.rdy", int'(in_ready), 1);
    check("rst.sign", int'(out_sign), 0);
    check("rst.exp", int'(out_exp), 0);
    check("rst.man", int'(out_man), 0);
    check("rst.ovf", int'(out_ovf), 0);
    check("rst.unf", int'(out_unf), 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(tbl[i], 0);

    v = tbl[0];
    v.nm = "bp";
    apply(v, 5);

    // reset while shifting in NORM
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 3'd5;
    in_raw   = 7'b0000110;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst.vld", int'(out_valid), 0);
    check("mid_rst.rdy", int'(in_ready), 1);
    check("mid_rst.sign", int'(out_sign), 0);
    check("mid_rst.exp", int'(out_exp), 0);
    check("mid_rst.man", int'(out_man), 0);
    check("mid_rst.ovf", int'(out_ovf), 0);
    check("mid_rst.unf", int'(out_unf), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    v = tbl[1];
    v.nm = "after_rst";
    apply(v, 0);

    for (int n = 0; n < 200; n++) begin
      v.nm = "rand";
      v.s  = 1'($urandom);
      v.e  = int'($urandom_range(0, 6));
      v.r  = int'($urandom_range(0, 127));
      model(v.e, v.r, v.xe, v.xm, v.xo, v.xu, v.xl);
      apply(v, (n % 17 == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
